rgb_fade_seq: RTL

//  Colour-sequencer stage directly upstream of the RGB PWM timer. Produces the three 8-bit

---
 rtl/rgb_fade_seq_pkg.sv | 46 ++++
 rtl/rgb_fade_seq_channel.sv | 51 +++++
 rtl/rgb_fade_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rgb_fade_seq_pkg.sv
// Shared definitions for the RGB fade sequencer: FSM states, the colour record and the
// fixed eight-entry palette with its duty-ceiling clamp.
package rgb_fade_seq_pkg;

  localparam int PAL_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t palette(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = {8'd124, 8'd0,   8'd0};
      3'd1:    c = {8'd124, 8'd62,  8'd0};
      3'd2:    c = {8'd0,   8'd124, 8'd0};
      3'd3:    c = {8'd0,   8'd124, 8'd124};
      3'd4:    c = {8'd0,   8'd0,   8'd124};
      3'd5:    c = {8'd124, 8'd0,   8'd124};
      3'd6:    c = {8'd124, 8'd124, 8'd124};
      default: c = {8'd0,   8'd0,   8'd0};
    endcase
    return c;
  endfunction

  function automatic logic [7:0] clampDuty(input logic [7:0] v, input logic [7:0] maxDuty);
    return (v > maxDuty) ? maxDuty : v;
  endfunction

  function automatic rgb_t clampRgb(input rgb_t c, input logic [7:0] maxDuty);
    rgb_t o;
    o.r = clampDuty(c.r, maxDuty);
    o.g = clampDuty(c.g, maxDuty);
    o.b = clampDuty(c.b, maxDuty);
    return o;
  endfunction

endpackage

// File: rtl/rgb_fade_seq_channel.sv
// One colour channel: registered duty that steps toward its target by at most one step
// per update, saturating exactly on the target.
module rgb_fade_seq_channel (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       update_i,
  input  logic [7:0] step_i,
  input  logic [7:0] target_i,
  output logic [7:0] duty_o,
  output logic [7:0] dutyNext_o,
  output logic       atTarget_o
);

  logic [7:0] duty_q;
  logic [7:0] duty_d;
  logic [8:0] diff;
  logic [8:0] delta;
  logic [8:0] sum;

  // Nine-bit arithmetic so a step larger than the remaining distance can never wrap.
  always_comb begin
    diff   = 9'd0;
    delta  = 9'd0;
    sum    = {1'b0, duty_q};
    duty_d = duty_q;
    if (duty_q < target_i) begin
      diff   = {1'b0, target_i} - {1'b0, duty_q};
      delta  = (diff < {1'b0, step_i}) ? diff : {1'b0, step_i};
      sum    = {1'b0, duty_q} + delta;
      duty_d = sum[8] ? 8'hFF : sum[7:0];
    end else if (duty_q > target_i) begin
      diff   = {1'b0, duty_q} - {1'b0, target_i};
      delta  = (diff < {1'b0, step_i}) ? diff : {1'b0, step_i};
      sum    = {1'b0, duty_q} - delta;
      duty_d = sum[8] ? 8'h00 : sum[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_q <= 8'd0;
    end else if (update_i) begin
      duty_q <= duty_d;
    end
  end

  assign duty_o     = duty_q;
  assign dutyNext_o = update_i ? duty_d : duty_q;
  assign atTarget_o = (duty_d == target_i);

endmodule

// File: rtl/rgb_fade_seq.sv
// Colour sequencer feeding the RGB PWM timer: fades the three duties toward each palette
// entry in turn, holds the colour for a fixed number of ticks, then moves on.
module rgb_fade_seq
  import rgb_fade_seq_pkg::*;
#(
  parameter int STEP       = 4,
  parameter int HOLD_TICKS = 50,
  parameter int MAX_DUTY   = 124
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       en_i,
  output logic [7:0] dutyR_o,
  output logic [7:0] dutyG_o,
  output logic [7:0] dutyB_o,
  output logic [2:0] seqIdx_o,
  output logic       atTarget_o,
  output logic       wrap_o
);

  localparam int STEP_EFF = (STEP <= 0) ? 1 : ((STEP > 255) ? 255 : STEP);
  localparam int HOLD_EFF = (HOLD_TICKS <= 0) ? 1 : HOLD_TICKS;
  localparam int HW       = $clog2(HOLD_EFF + 1);
  localparam int MAX_EFF  = (MAX_DUTY < 0) ? 0 : ((MAX_DUTY > 255) ? 255 : MAX_DUTY);

  localparam logic [7:0]    STEP_V    = 8'(STEP_EFF);
  localparam logic [7:0]    MAX_V     = 8'(MAX_EFF);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_EFF);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [2:0]    LAST_IDX  = 3'(PAL_LEN - 1);

  state_e        state_q, state_d;
  logic [2:0]    seqIdx_q, seqIdx_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic          atTarget_q, atTarget_d;
  logic          wrap_q, wrap_d;
  logic          fadeUpd;
  rgb_t          curTgt;
  rgb_t          nextTgt;
  logic [7:0]    nextR, nextG, nextB;
  logic          atR, atG, atB;

  assign curTgt  = clampRgb(palette(seqIdx_q), MAX_V);
  assign nextTgt = clampRgb(palette(seqIdx_d), MAX_V);
  assign fadeUpd = en_i && tick_i && (state_q == ST_FADE);

  rgb_fade_seq_channel uChanR (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .update_i   (fadeUpd),
    .step_i     (STEP_V),
    .target_i   (curTgt.r),
    .duty_o     (dutyR_o),
    .dutyNext_o (nextR),
    .atTarget_o (atR)
  );

  rgb_fade_seq_channel uChanG (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .update_i   (fadeUpd),
    .step_i     (STEP_V),
    .target_i   (curTgt.g),
    .duty_o     (dutyG_o),
    .dutyNext_o (nextG),
    .atTarget_o (atG)
  );

  rgb_fade_seq_channel uChanB (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .update_i   (fadeUpd),
    .step_i     (STEP_V),
    .target_i   (curTgt.b),
    .duty_o     (dutyB_o),
    .dutyNext_o (nextB),
    .atTarget_o (atB)
  );

  // The hold counter only moves on ticks; the entry advances on the tick that finds it at one.
  always_comb begin
    state_d   = state_q;
    seqIdx_d  = seqIdx_q;
    holdCnt_d = holdCnt_q;
    wrap_d    = 1'b0;
    if (en_i) begin
      case (state_q)
        ST_IDLE: state_d = ST_FADE;
        ST_FADE: begin
          if (tick_i && atR && atG && atB) begin
            state_d   = ST_HOLD;
            holdCnt_d = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (tick_i) begin
            if (holdCnt_q == HOLD_ONE) begin
              seqIdx_d = seqIdx_q + 3'd1;
              state_d  = ST_FADE;
              wrap_d   = (seqIdx_q == LAST_IDX);
            end else begin
              holdCnt_d = holdCnt_q - HOLD_ONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Looks ahead at the duties and entry that will be current after this edge.
  assign atTarget_d = (nextR == nextTgt.r) && (nextG == nextTgt.g) && (nextB == nextTgt.b);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      seqIdx_q   <= 3'd0;
      holdCnt_q  <= '0;
      atTarget_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seqIdx_q  <= seqIdx_d;
      holdCnt_q <= holdCnt_d;
      wrap_q    <= wrap_d;
      if (en_i) begin
        atTarget_q <= atTarget_d;
      end
    end
  end

  assign seqIdx_o   = seqIdx_q;
  assign atTarget_o = atTarget_q;
  assign wrap_o     = wrap_q;

endmodule
